muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand, HI and LO width; legal values are even and at least 4.
REQ-002 Parameter SIGNED_EN, default 1: when 0, signed ops execute as their unsigned counterparts.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  op request strobe, sampled on the rising edge.
REQ-006 op  input  4  operation code (values in muldiv_pkg).
REQ-007 a, b  input  WIDTH  operands (multiplicand/dividend, multiplier/divisor).
REQ-008 flush  input  1  abort the in-flight mul/div.
REQ-009 busy  output  1  a mul/div is in flight.
REQ-010 stall  output  1  pipeline must hold the requesting instruction.
REQ-011 done  output  1  single-cycle pulse: HI/LO were just written by a mul/div.
REQ-012 result  output  WIDTH  MFHI/MFLO read data.
REQ-013 hi, lo  output  WIDTH  architectural HI/LO registers.

Function
REQ-014 Opcodes shall be: MULTU=0011, MFLO=0101, MFHI=0100, MULT=0010, DIV=0110, DIVU=0111, MTHI=1000, MTLO=1001; all other codes are NOP.
REQ-015 FSM states shall be IDLE, MUL, DIV and FIX.
REQ-016 IDLE + start + MULT/MULTU: latch operand magnitudes and the result sign, clear counter, go to MUL.
REQ-017 IDLE + start + DIV/DIVU: latch operand magnitudes and the result sign, clear counter, go to DIV.
REQ-018 MUL shall run radix-2 shift-add for exactly WIDTH cycles, then go to FIX.
REQ-019 DIV shall run restoring division for exactly WIDTH cycles, then go to FIX.
REQ-020 FIX shall apply sign correction, write HI/LO, pulse done and return to IDLE.
REQ-021 Latency: start sampled at edge 0 -> HI/LO updated and done high after edge WIDTH+1; busy high from edge 0 to edge WIDTH+1.
REQ-022 Multiply: {hi,lo} = full 2*WIDTH-bit product; signed ops use the two's-complement product.
REQ-023 Divide: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
REQ-024 Divide by zero: lo = all ones, hi = a, same latency, no exception.
REQ-025 Signed MIN / -1: lo = MIN, hi = 0.
REQ-026 MTHI/MTLO + start while idle: write a into hi/lo at the next edge; busy stays low; no done.
REQ-027 result = hi for MFHI and lo for MFLO (combinational from registers), else 0.
REQ-028 stall = start & busy & (op is any mul/div/MFHI/MFLO/MTHI/MTLO); while busy the request is ignored, not queued.
REQ-029 start with a NOP code shall have no effect.
REQ-030 flush while busy: return to IDLE next edge; hi/lo unchanged; no done.
REQ-031 flush while idle has no effect.
REQ-032 flush and start in the same cycle: flush wins and the start is dropped.
REQ-033 done and a new start in the same cycle: the start is accepted, since busy is already low in that cycle.

Reset
REQ-034 rst_n low shall immediately force state IDLE and clear busy, done, hi, lo, the counter and the datapath registers.
REQ-035 Reset during an operation shall discard the operation; result reads 0 after reset.

Structure
REQ-036 muldiv_pkg shall hold the opcode localparams, the FSM state enum and the op-class decode function.
REQ-037 The iteration datapath (shared WIDTH+1-bit adder/subtractor and shift registers) shall be one sub-module, muldiv_core; the FSM, HI/LO registers and handshake shall stay in muldiv_unit.

Verification
REQ-038 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, done 1 cycle.
REQ-039 MULT a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then MFLO -> result=0xFFFFFFEB.
REQ-040 DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-041 MFHI requested 5 cycles after MULT start -> stall=1 until done; second MULT start while busy ignored.
REQ-042 flush at cycle 10 of a DIV -> busy low next cycle, no done, hi/lo keep prior values; rst_n low mid-MUL -> all outputs 0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: opcodes, FSM states
// and the opcode classifier used by both the unit and its users.
package muldiv_pkg;

    localparam logic [3:0] OP_MULT  = 4'b0010;
    localparam logic [3:0] OP_MULTU = 4'b0011;
    localparam logic [3:0] OP_MFHI  = 4'b0100;
    localparam logic [3:0] OP_MFLO  = 4'b0101;
    localparam logic [3:0] OP_DIV   = 4'b0110;
    localparam logic [3:0] OP_DIVU  = 4'b0111;
    localparam logic [3:0] OP_MTHI  = 4'b1000;
    localparam logic [3:0] OP_MTLO  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } state_e;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_MUL,
        CLS_DIV,
        CLS_MFHI,
        CLS_MFLO,
        CLS_MTHI,
        CLS_MTLO
    } op_class_e;

    typedef struct packed {
        op_class_e cls;
        logic      is_signed;
    } op_decode_t;

    // Unknown codes fall through to CLS_NOP so they never touch any state.
    function automatic op_decode_t decode_op(input logic [3:0] op);
        op_decode_t d;
        d.cls       = CLS_NOP;
        d.is_signed = 1'b0;
        case (op)
            OP_MULT:  begin d.cls = CLS_MUL; d.is_signed = 1'b1; end
            OP_MULTU: d.cls = CLS_MUL;
            OP_DIV:   begin d.cls = CLS_DIV; d.is_signed = 1'b1; end
            OP_DIVU:  d.cls = CLS_DIV;
            OP_MFHI:  d.cls = CLS_MFHI;
            OP_MFLO:  d.cls = CLS_MFLO;
            OP_MTHI:  d.cls = CLS_MTHI;
            OP_MTLO:  d.cls = CLS_MTLO;
            default:  d.cls = CLS_NOP;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the pipeline (master) and the muldiv unit (slave).
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, stall, done, result, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, stall, done, result, hi, lo
    );
endinterface

// File: rtl/muldiv_core.sv
// Iterative magnitude datapath: one bit per step of shift-add multiply or
// restoring divide, sharing a single WIDTH+1-bit adder/subtractor.
module muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] load_lo,
    input  logic [WIDTH-1:0] load_opd,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] shreg
);

    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] sh_reg, sh_next;
    logic [WIDTH-1:0] opd_reg;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   add_x, add_y;
    logic             add_cin;
    logic [WIDTH+1:0] add_sum;

    // The extra top bit is the carry; for subtraction it means "no borrow".
    assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_cin};

    always_comb begin
        shifted  = {acc_reg, sh_reg[WIDTH-1]};
        add_x    = {1'b0, acc_reg};
        add_y    = '0;
        add_cin  = 1'b0;
        acc_next = acc_reg;
        sh_next  = sh_reg;
        if (load) begin
            acc_next = '0;
            sh_next  = load_lo;
        end else if (step) begin
            if (div_mode) begin
                // Remainder shifts left pulling in the next dividend bit; the
                // quotient bit enters at the bottom of the same register.
                add_x    = shifted;
                add_y    = ~{1'b0, opd_reg};
                add_cin  = 1'b1;
                acc_next = add_sum[WIDTH+1] ? add_sum[WIDTH-1:0] : shifted[WIDTH-1:0];
                sh_next  = {sh_reg[WIDTH-2:0], add_sum[WIDTH+1]};
            end else begin
                add_y    = sh_reg[0] ? {1'b0, opd_reg} : '0;
                acc_next = add_sum[WIDTH:1];
                sh_next  = {add_sum[0], sh_reg[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
            sh_reg  <= '0;
            opd_reg <= '0;
        end else begin
            acc_reg <= acc_next;
            sh_reg  <= sh_next;
            if (load) begin
                opd_reg <= load_opd;
            end
        end
    end

    assign acc   = acc_reg;
    assign shreg = sh_reg;

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: control FSM, sign handling, HI/LO registers and
// the pipeline handshake around the iterative muldiv_core datapath.
module muldiv_unit #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);
    import muldiv_pkg::*;

    localparam int CW = $clog2(WIDTH) + 1;

    state_e           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic             done_reg;
    logic             prod_neg_reg, rem_neg_reg, div0_reg, is_div_reg;

    op_decode_t       dec;
    logic             op_signed, a_neg, b_neg, accept, busy_int;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             core_load, core_step, core_div;
    logic [WIDTH-1:0] core_lo_in, core_opd_in;
    logic [WIDTH-1:0] core_acc, core_sh;
    logic             write_hilo;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix, fix_hi, fix_lo;

    assign dec       = decode_op(bus.op);
    assign op_signed = dec.is_signed && SIGNED_EN;
    assign a_neg     = op_signed && bus.a[WIDTH-1];
    assign b_neg     = op_signed && bus.b[WIDTH-1];
    assign mag_a     = a_neg ? -bus.a : bus.a;
    assign mag_b     = b_neg ? -bus.b : bus.b;
    assign busy_int  = (state_reg != ST_IDLE);
    // A flush in the same cycle cancels any new request.
    assign accept    = bus.start && !bus.flush && !busy_int;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        core_load   = 1'b0;
        core_step   = 1'b0;
        core_div    = 1'b0;
        core_lo_in  = mag_b;
        core_opd_in = mag_a;
        write_hilo  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept && dec.cls == CLS_MUL) begin
                    core_load  = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_MUL;
                end else if (accept && dec.cls == CLS_DIV) begin
                    // Dividend goes into the shift register, divisor is the operand.
                    core_load   = 1'b1;
                    core_lo_in  = mag_a;
                    core_opd_in = mag_b;
                    cnt_next    = '0;
                    state_next  = ST_DIV;
                end
            end
            ST_MUL, ST_DIV: begin
                if (bus.flush) begin
                    state_next = ST_IDLE;
                end else begin
                    core_step = 1'b1;
                    core_div  = (state_reg == ST_DIV);
                    cnt_next  = cnt_reg + CW'(1);
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        state_next = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                state_next = ST_IDLE;
                write_hilo = !bus.flush;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Sign correction of the magnitude results; divide-by-zero forces an
    // all-ones quotient while the remainder path naturally reproduces a.
    always_comb begin
        prod_raw = {core_acc, core_sh};
        prod_fix = prod_neg_reg ? -prod_raw : prod_raw;
        quo_fix  = div0_reg ? '1 : (prod_neg_reg ? -core_sh : core_sh);
        rem_fix  = rem_neg_reg ? -core_acc : core_acc;
        fix_hi   = is_div_reg ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = is_div_reg ? quo_fix : prod_fix[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
            prod_neg_reg <= 1'b0;
            rem_neg_reg  <= 1'b0;
            div0_reg     <= 1'b0;
            is_div_reg   <= 1'b0;
        end else begin
            done_reg <= write_hilo;
            if (core_load) begin
                prod_neg_reg <= a_neg ^ b_neg;
                rem_neg_reg  <= a_neg;
                div0_reg     <= (dec.cls == CLS_DIV) && (bus.b == '0);
                is_div_reg   <= (dec.cls == CLS_DIV);
            end
            if (write_hilo) begin
                hi_reg <= fix_hi;
                lo_reg <= fix_lo;
            end else if (accept && dec.cls == CLS_MTHI) begin
                hi_reg <= bus.a;
            end else if (accept && dec.cls == CLS_MTLO) begin
                lo_reg <= bus.a;
            end
        end
    end

    muldiv_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (core_load),
        .step     (core_step),
        .div_mode (core_div),
        .load_lo  (core_lo_in),
        .load_opd (core_opd_in),
        .acc      (core_acc),
        .shreg    (core_sh)
    );

    assign bus.busy   = busy_int;
    assign bus.done   = done_reg;
    assign bus.hi     = hi_reg;
    assign bus.lo     = lo_reg;
    assign bus.stall  = bus.start && busy_int && (dec.cls != CLS_NOP);
    assign bus.result = (dec.cls == CLS_MFHI) ? hi_reg :
                        (dec.cls == CLS_MFLO) ? lo_reg : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus randomized bench for muldiv_unit; expected HI/LO come from a
// plain-arithmetic reference model of multiply/divide semantics.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;
    localparam logic [3:0] OP_NOP = 4'hF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(
        .WIDTH    (W),
        .SIGNED_EN(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference semantics: {hi, lo}
    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        longint px, py;
        int     sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            OP_MULTU: return {32'd0, x} * {32'd0, y};
            OP_MULT: begin
                px = sx;
                py = sy;
                return px * py;
            end
            OP_DIVU: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            OP_DIV: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {sx % sy, sx / sy};
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] e;
        int n;
        e = model(o, x, y);
        bus.op = o; bus.a = x; bus.b = y; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.op = OP_NOP;
        chk({name, "_busy"}, bus.busy, 1);
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk({name, "_latency"}, n, W + 1);
        chk({name, "_hi"}, bus.hi, e[63:32]);
        chk({name, "_lo"}, bus.lo, e[31:0]);
        chk({name, "_busy_end"}, bus.busy, 0);
        exp_hi = e[63:32];
        exp_lo = e[31:0];
        $display("[TB] %s op=%h a=%h b=%h hi=%h lo=%h", name, o, x, y, bus.hi, bus.lo);
        tick();
        chk({name, "_done_pulse"}, bus.done, 0);
    endtask

    initial begin
        logic [63:0] e, e2;
        logic [3:0]  o;
        logic [31:0] x, y;
        logic        ok;
        int          n;

        bus.start = 1'b0; bus.op = OP_NOP; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
        tick();
        tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        $display("[TB] reset busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
        rst_n = 1'b1;
        tick();

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max_hi_const", bus.hi, 32'hFFFF_FFFE);
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7);
        bus.op = OP_MFLO; bus.start = 1'b1; #1;
        chk("mflo_result", bus.result, 32'hFFFF_FFEB);
        chk("mflo_no_stall", bus.stall, 0);
        tick();
        bus.op = OP_MFHI; #1;
        chk("mfhi_result", bus.result, exp_hi);
        tick();
        bus.start = 1'b0; bus.op = OP_NOP; #1;
        chk("nop_result", bus.result, 0);
        $display("[TB] mf reads hi=%h lo=%h", exp_hi, exp_lo);

        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_zero", OP_DIVU, 32'd7, 32'd0);
        run_op("div_zero_neg", OP_DIV, 32'hFFFF_FF00, 32'd0);
        run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000);

        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 3))
                0: o = OP_MULT;
                1: o = OP_MULTU;
                2: o = OP_DIV;
                default: o = OP_DIVU;
            endcase
            x = pick_operand();
            y = pick_operand();
            run_op("rand", o, x, y);
        end

        // MTHI / MTLO
        bus.op = OP_MTHI; bus.a = 32'hCAFE_0001; bus.start = 1'b1;
        tick();
        chk("mthi_hi", bus.hi, 32'hCAFE_0001);
        chk("mthi_busy", bus.busy, 0);
        chk("mthi_lo_kept", bus.lo, exp_lo);
        bus.op = OP_MTLO; bus.a = 32'hBEEF_0002;
        tick();
        bus.start = 1'b0; bus.op = OP_NOP;
        chk("mtlo_lo", bus.lo, 32'hBEEF_0002);
        chk("mt_no_done", bus.done, 0);
        exp_hi = 32'hCAFE_0001;
        exp_lo = 32'hBEEF_0002;
        $display("[TB] mthi/mtlo hi=%h lo=%h", bus.hi, bus.lo);

        // NOP start and idle flush change nothing
        bus.op = 4'hA; bus.a = 32'h1234_5678; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("nop_busy", bus.busy, 0);
        chk("nop_hi", bus.hi, exp_hi);
        chk("nop_lo", bus.lo, exp_lo);
        $display("[TB] nop/idle flush hi=%h lo=%h", bus.hi, bus.lo);

        // flush and start in the same cycle: start dropped
        bus.op = OP_MULT; bus.a = 32'd5; bus.b = 32'd5; bus.start = 1'b1; bus.flush = 1'b1;
        tick();
        bus.start = 1'b0; bus.flush = 1'b0; bus.op = OP_NOP;
        chk("flush_start_busy", bus.busy, 0);
        $display("[TB] flush+start busy=%b", bus.busy);

        // stall while busy; second MULT ignored; MFHI held until done
        e = model(OP_MULT, 32'd12345, 32'hFFFF_FF00);
        bus.op = OP_MULT; bus.a = 32'd12345; bus.b = 32'hFFFF_FF00; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.op = OP_NOP;
        tick();
        tick();
        bus.op = OP_MULT; bus.a = 32'd9; bus.b = 32'd9; bus.start = 1'b1; #1;
        chk("stall_mult", bus.stall, 1);
        tick();
        bus.start = 1'b0; bus.op = OP_NOP; #1;
        chk("stall_idle_req", bus.stall, 0);
        tick();
        tick();
        bus.op = OP_MFHI; bus.start = 1'b1; #1;
        n = 5;
        ok = 1'b1;
        while (bus.done !== 1'b1 && n < 100) begin
            if (bus.stall !== 1'b1) ok = 1'b0;
            tick();
            n++;
        end
        chk("stall_held", ok, 1);
        chk("stall_latency", n, W + 1);
        chk("stall_release", bus.stall, 0);
        chk("stall_mfhi", bus.result, e[63:32]);
        chk("stall_lo", bus.lo, e[31:0]);
        bus.start = 1'b0; bus.op = OP_NOP;
        exp_hi = e[63:32];
        exp_lo = e[31:0];
        tick();
        chk("second_mult_dropped", bus.busy, 0);
        $display("[TB] stall test hi=%h lo=%h", bus.hi, bus.lo);

        // flush at cycle 10 of a DIV
        bus.op = OP_DIV; bus.a = 32'd1000; bus.b = 32'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.op = OP_NOP;
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_busy", bus.busy, 0);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) ok = 1'b1;
            tick();
        end
        chk("flush_no_done", ok, 0);
        chk("flush_hi", bus.hi, exp_hi);
        chk("flush_lo", bus.lo, exp_lo);
        $display("[TB] flush div hi=%h lo=%h", bus.hi, bus.lo);

        // done and new start in the same cycle
        e = model(OP_DIVU, 32'd1000, 32'd7);
        e2 = model(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
        bus.op = OP_DIVU; bus.a = 32'd1000; bus.b = 32'd7; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.op = OP_NOP;
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("b2b_first_lo", bus.lo, e[31:0]);
        bus.op = OP_MULTU; bus.a = 32'h1234_5678; bus.b = 32'h9ABC_DEF0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.op = OP_NOP;
        chk("b2b_accept", bus.busy, 1);
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("b2b_latency", n, W + 1);
        chk("b2b_hi", bus.hi, e2[63:32]);
        chk("b2b_lo", bus.lo, e2[31:0]);
        $display("[TB] back-to-back hi=%h lo=%h", bus.hi, bus.lo);
        tick();

        // asynchronous reset in the middle of a MUL
        bus.op = OP_MULT; bus.a = 32'd77; bus.b = 32'd88; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (7) tick();
        bus.op = OP_MFHI;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_hi", bus.hi, 0);
        chk("arst_lo", bus.lo, 0);
        chk("arst_result", bus.result, 0);
        chk("arst_stall", bus.stall, 0);
        $display("[TB] reset mid-mul busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
        tick();
        rst_n = 1'b1;
        bus.op = OP_NOP;
        tick();
        run_op("post_reset", OP_MULTU, 32'd6, 32'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
